// File: rtl/sram_template_multiway.sv
// Single-port SETS x WAYS x WIDTH storage array with per-way write mask, 1-cycle registered read,
// optional read-data hold and an optional post-reset zeroing sweep.
module sram_template_multiway #(
  parameter int SETS         = 64,
  parameter int WAYS         = 4,
  parameter int WIDTH        = 64,
  parameter int SHOULD_RESET = 1,
  parameter int HOLD_READ    = 1,
  localparam int SET_W       = $clog2(SETS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_rreq_valid,
  output logic                  io_rreq_ready,
  input  logic [SET_W-1:0]      io_rreq_bits_setIdx,
  output logic                  io_rresp_valid,
  output logic [WAYS*WIDTH-1:0] io_rresp_data,
  input  logic                  io_wreq_valid,
  output logic                  io_wreq_ready,
  input  logic [SET_W-1:0]      io_wreq_bits_setIdx,
  input  logic [WAYS*WIDTH-1:0] io_wreq_bits_data,
  input  logic [WAYS-1:0]       io_wreq_bits_waymask,
  output logic                  io_init_done,
  output logic                  dbg_state
);

  // Handshake: a request transfers on a cycle where valid & ready are both high; valid must not
  // depend on ready. Writes win the single port, so a colliding read sees ready=0 and must retry.

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [SET_W-1:0]        cnt_q, cnt_d;
  logic                    rresp_valid_q, rresp_valid_d;
  logic [WAYS*WIDTH-1:0]   rresp_data_q, rresp_data_d;
  logic [WIDTH-1:0]        mem_q [SETS][WAYS];

  logic                    rd_fire, wr_fire;
  logic                    mem_we;
  logic [SET_W-1:0]        mem_set;
  logic [WAYS*WIDTH-1:0]   mem_wdata;
  logic [WAYS-1:0]         mem_mask;
  logic [WAYS*WIDTH-1:0]   read_row;

  assign io_init_done   = (state_q == ST_IDLE);
  assign io_wreq_ready  = io_init_done;
  assign io_rreq_ready  = io_init_done & ~io_wreq_valid;
  assign io_rresp_valid = rresp_valid_q;
  assign io_rresp_data  = rresp_data_q;
  assign dbg_state      = state_q;

  assign rd_fire = io_rreq_valid & io_rreq_ready;
  assign wr_fire = io_wreq_valid & io_wreq_ready;

  always_comb begin
    read_row = '0;
    for (int w = 0; w < WAYS; w++) begin
      read_row[w*WIDTH +: WIDTH] = mem_q[io_rreq_bits_setIdx][w];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_set   = io_wreq_bits_setIdx;
    mem_wdata = io_wreq_bits_data;
    mem_mask  = io_wreq_bits_waymask;
    case (state_q)
      ST_INIT: begin
        // Sweep clears one whole set per cycle, leaving after the last set.
        mem_we    = 1'b1;
        mem_set   = cnt_q;
        mem_wdata = '0;
        mem_mask  = '1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == SET_W'(SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        mem_we = wr_fire;
      end
    endcase
  end

  always_comb begin
    rresp_valid_d = rd_fire;
    rresp_data_d  = (HOLD_READ != 0) ? rresp_data_q : '0;
    if (rd_fire) begin
      rresp_data_d = read_row;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= (SHOULD_RESET != 0) ? ST_INIT : ST_IDLE;
      cnt_q         <= '0;
      rresp_valid_q <= 1'b0;
      rresp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rresp_valid_q <= rresp_valid_d;
      rresp_data_q  <= rresp_data_d;
    end
  end

  // Array itself has no reset; the sweep is what zeroes it.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mem_mask[w]) begin
          mem_q[mem_set][w] <= mem_wdata[w*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule
